// File: rtl/wb_scoreboard_pkg.sv
// Shared types and defaults for the writeback scoreboard.
// Holds the FSM encoding, default parameter values and a saturating counter helper.
package wb_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } sb_state_e;

  localparam int unsigned SB_DATA_W     = 32;
  localparam int unsigned SB_NUM_REGS   = 16;
  localparam int unsigned SB_NUM_WPORTS = 2;
  localparam int unsigned SB_TIMEOUT    = 2500;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wb_shadow_rf.sv
// Shadow register file: NUM_WPORTS write ports, one combinational read port.
// Highest-numbered port wins on a same-address collision; clr_i zeroes every entry.
module wb_shadow_rf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_i,
  input  logic [NUM_WPORTS-1:0]        wr_en_i,
  input  logic [NUM_WPORTS*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WPORTS*DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic [DATA_W-1:0]            rd_data_o
);

  localparam int unsigned NREGS_EXT = NUM_REGS;
  localparam logic [ADDR_W:0] NREGS_W = NREGS_EXT[ADDR_W:0];

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Ports are applied in ascending order so the last (highest) writer sticks.
  always_comb begin
    regs_d = regs_q;
    if (clr_i) begin
      for (int r = 0; r < int'(NUM_REGS); r++) regs_d[r] = '0;
    end else begin
      for (int p = 0; p < int'(NUM_WPORTS); p++) begin
        if (wr_en_i[p] && ({1'b0, wr_addr_i[p*ADDR_W +: ADDR_W]} < NREGS_W)) begin
          regs_d[wr_addr_i[p*ADDR_W +: ADDR_W]] = wr_data_i[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(NUM_REGS); r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data_o = regs_q[rd_addr_i];

endmodule

// File: rtl/wb_scoreboard.sv
// Shadows register writebacks during a run, then walks the expected table one index per cycle.
// Reports pass/fail, mismatch count, first failing index and run length until the next start.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = SB_DATA_W,
  parameter int unsigned NUM_REGS   = SB_NUM_REGS,
  parameter int unsigned NUM_WPORTS = SB_NUM_WPORTS,
  parameter int unsigned TIMEOUT    = SB_TIMEOUT,
  localparam int unsigned ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         halt,
  input  logic [NUM_WPORTS-1:0]        wr_en,
  input  logic [NUM_WPORTS*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WPORTS*DATA_W-1:0] wr_data,
  input  logic                         exp_we,
  input  logic [ADDR_W-1:0]            exp_idx,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic                         exp_chk,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [ADDR_W:0]              mismatch_cnt,
  output logic [ADDR_W-1:0]            first_fail,
  output logic [31:0]                  cycle_cnt
);

  localparam int unsigned NREGS_EXT = NUM_REGS;
  localparam int unsigned LAST_EXT  = NUM_REGS - 1;
  localparam logic [ADDR_W:0]   NREGS_W  = NREGS_EXT[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_IDX = LAST_EXT[ADDR_W-1:0];

  sb_state_e         state_q, state_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   mism_q, mism_d;
  logic [ADDR_W-1:0] ff_q, ff_d;
  logic              tmo_q, tmo_d;

  logic [DATA_W-1:0]   exp_data_q [NUM_REGS];
  logic [NUM_REGS-1:0] exp_chk_q;

  logic              start_acc, tmo_hit, exp_wr, mis_hit;
  logic [32:0]       cyc_next;
  logic [DATA_W-1:0] rd_data;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cyc_next  = {1'b0, cycle_cnt_q} + 33'd1;
  assign tmo_hit   = (cyc_next >= 33'(TIMEOUT));
  assign exp_wr    = exp_we && (state_q != ST_CHECK) && ({1'b0, exp_idx} < NREGS_W);
  assign mis_hit   = (state_q == ST_CHECK) && exp_chk_q[idx_q] && (rd_data != exp_data_q[idx_q]);

  wb_shadow_rf #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .NUM_WPORTS(NUM_WPORTS),
    .ADDR_W    (ADDR_W)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (start_acc),
    .wr_en_i  ((state_q == ST_RUN) ? wr_en : '0),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i(idx_q),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (halt || tmo_hit) state_d = ST_CHECK;
      ST_CHECK:         if (idx_q == LAST_IDX) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == ST_RUN) || (state_q == ST_CHECK);
    done         = (state_q == ST_DONE);
    pass         = done && (mism_q == '0) && !tmo_q;
    timeout      = done && tmo_q;
    mismatch_cnt = mism_q;
    first_fail   = ff_q;
    cycle_cnt    = cycle_cnt_q;
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    idx_d       = idx_q;
    mism_d      = mism_q;
    ff_d        = ff_q;
    tmo_d       = tmo_q;
    if (start_acc) begin
      cycle_cnt_d = '0;
      idx_d       = '0;
      mism_d      = '0;
      ff_d        = '0;
      tmo_d       = 1'b0;
    end else if (state_q == ST_RUN) begin
      cycle_cnt_d = sat_inc32(cycle_cnt_q);
      idx_d       = '0;
      // A halt arriving on the limit cycle still counts as a clean finish.
      if (tmo_hit && !halt) tmo_d = 1'b1;
    end else if (state_q == ST_CHECK) begin
      idx_d = idx_q + 1'b1;
      if (mis_hit) begin
        mism_d = mism_q + 1'b1;
        if (mism_q == '0) ff_d = idx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      idx_q       <= '0;
      mism_q      <= '0;
      ff_q        <= '0;
      tmo_q       <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      idx_q       <= idx_d;
      mism_q      <= mism_d;
      ff_q        <= ff_d;
      tmo_q       <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(NUM_REGS); r++) exp_data_q[r] <= '0;
      exp_chk_q <= '0;
    end else if (exp_wr) begin
      exp_data_q[exp_idx] <= exp_data;
      exp_chk_q[exp_idx]  <= exp_chk;
    end
  end

endmodule
